// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset main control FSM with memory-stall handshake and retired-instruction counter.
// Build option ILLEGAL_TRAP_EN: illegal opcodes halt the core instead of retiring as NOPs.
`timescale 1ns/1ps

// state    | meaning
// IDLE     | post-reset, all outputs 0
// FETCH    | read instruction at PC, PC+4; waits for memory ready
// DECODE   | latch opcode class, precompute branch target
// MEM_ADDR | compute rs + sign-ext imm
// MEM_RD   | load access, waits for memory ready
// MEM_WB   | write MDR to rt
// MEM_WR   | store access, waits for memory ready
// EXEC_R   | R-type ALU operation
// EXEC_I   | immediate ALU operation
// ALU_WB   | write ALUOut to rd/rt
// BRANCH   | compare and conditionally load branch target
// JUMP     | load jump address
// HALT     | trapped on illegal opcode
module multicycle_ctrl #(
    parameter int COUNT_W = 32
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [5:0]         opcode_i,
    input  logic               mem_ready_i,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic               branch_eq_o,
    output logic               ir_write_o,
    output logic               iord_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [1:0]         alu_op_o,
    output logic [1:0]         pc_source_o,
    output logic               halt_o,
    output logic [3:0]         state_o,
    output logic [COUNT_W-1:0] instr_count_o
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_EXEC_I   = 4'd8;
    localparam logic [3:0] S_ALU_WB   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [2:0] C_NONE = 3'd0;
    localparam logic [2:0] C_R    = 3'd1;
    localparam logic [2:0] C_LW   = 3'd2;
    localparam logic [2:0] C_SW   = 3'd3;
    localparam logic [2:0] C_BEQ  = 3'd4;
    localparam logic [2:0] C_BNE  = 3'd5;
    localparam logic [2:0] C_I    = 3'd6;
    localparam logic [2:0] C_J    = 3'd7;

    logic [3:0]         state_q, state_next;
    logic [2:0]         cls_q, dec_cls;
    logic [COUNT_W-1:0] count_q;
    logic               retire;

    function automatic logic [2:0] op_class(input logic [5:0] op);
        case (op)
            6'h00:        return C_R;
            6'h23:        return C_LW;
            6'h2B:        return C_SW;
            6'h04:        return C_BEQ;
            6'h05:        return C_BNE;
            6'h08, 6'h0A: return C_I;
            6'h02:        return C_J;
            default:      return C_NONE;
        endcase
    endfunction

    assign dec_cls = op_class(opcode_i);

    always_comb begin
        state_next = state_q;
        retire     = 1'b0;
        case (state_q)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH:    if (mem_ready_i) state_next = S_DECODE;
            S_DECODE: begin
                case (dec_cls)
                    C_R:          state_next = S_EXEC_R;
                    C_LW, C_SW:   state_next = S_MEM_ADDR;
                    C_BEQ, C_BNE: state_next = S_BRANCH;
                    C_I:          state_next = S_EXEC_I;
                    C_J:          state_next = S_JUMP;
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        state_next = S_HALT;
`else
                        state_next = S_FETCH;
                        retire     = 1'b1;
`endif
                    end
                endcase
            end
            S_MEM_ADDR: state_next = (cls_q == C_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) state_next = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready_i) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT:     state_next = S_HALT;
`else
            S_HALT:     state_next = S_IDLE;
`endif
            default:    state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cls_q   <= C_NONE;
            count_q <= '0;
        end else begin
            state_q <= state_next;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            if (retire) count_q <= count_q + COUNT_W'(1);
        end
    end

    // Moore decode; only FETCH's IR/PC load looks at mem_ready_i.
    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_eq_o     = 1'b0;
        ir_write_o      = 1'b0;
        iord_o          = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        alu_op_o        = 2'b00;
        pc_source_o     = 2'b00;
        halt_o          = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE:   alu_src_b_o = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_RD: begin
                iord_o     = 1'b1;
                mem_read_o = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEM_WR: begin
                iord_o      = 1'b1;
                mem_write_o = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 2'b11;
            end
            S_ALU_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (cls_q == C_R);
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = 2'b01;
                pc_write_cond_o = 1'b1;
                pc_source_o     = 2'b01;
                branch_eq_o     = (cls_q == C_BEQ);
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = 2'b10;
            end
            S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
                halt_o = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign state_o       = state_q;
    assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: expected per-cycle trace built from instruction type and stall counts,
// compared against the DUT every cycle. Honours ILLEGAL_TRAP_EN when the build defines it.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

    localparam int CW = 4;

    typedef struct packed {
        logic       pc_write, pc_write_cond, branch_eq, ir_write, iord, mem_read;
        logic       mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_source;
        logic       halt;
    } ctl_t;

    typedef struct {
        logic [3:0] st;
        logic [5:0] op;
        logic       rdy;
        bit         retire;
        ctl_t       ctl;
    } ent_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [5:0]    opcode_i = '0;
    logic          mem_ready_i = 1'b0;
    logic          pc_write_o, pc_write_cond_o, branch_eq_o, ir_write_o, iord_o, mem_read_o;
    logic          mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, halt_o;
    logic [1:0]    alu_src_b_o, alu_op_o, pc_source_o;
    logic [3:0]    state_o;
    logic [CW-1:0] instr_count_o;

    multicycle_ctrl #(.COUNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .mem_ready_i(mem_ready_i),
        .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .branch_eq_o(branch_eq_o),
        .ir_write_o(ir_write_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o), .reg_dst_o(reg_dst_o),
        .reg_write_o(reg_write_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
        .alu_op_o(alu_op_o), .pc_source_o(pc_source_o), .halt_o(halt_o),
        .state_o(state_o), .instr_count_o(instr_count_o)
    );

    always #5 clk_i = ~clk_i;

    ctl_t dut_ctl;
    assign dut_ctl = ctl_t'({pc_write_o, pc_write_cond_o, branch_eq_o, ir_write_o, iord_o,
                             mem_read_o, mem_write_o, mem_to_reg_o, reg_dst_o, reg_write_o,
                             alu_src_a_o, alu_src_b_o, alu_op_o, pc_source_o, halt_o});

    int            checks = 0;
    int            failures = 0;
    ent_t          q[$];
    logic [CW-1:0] mcount = '0;

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic void push(input logic [3:0] st, input logic [5:0] op, input logic rdy,
                                 input bit retire, input ctl_t c);
        ent_t e;
        e.st = st; e.op = op; e.rdy = rdy; e.retire = retire; e.ctl = c;
        q.push_back(e);
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h02};
    endfunction

    // Appends one instruction's expected cycles; returns FETCH-to-FETCH length.
    function automatic int add_instr(input logic [5:0] op, input int fs, input int ms);
        int   n = 0;
        ctl_t c;
        for (int i = 0; i <= fs; i++) begin
            c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
            c.ir_write = (i == fs); c.pc_write = (i == fs);
            push(4'd1, op, i == fs, 0, c); n++;
        end
        c = '0; c.alu_src_b = 2'b11;
        push(4'd2, op, rnd(), !legal(op) && !TRAP, c); n++;
        case (op)
            6'h00, 6'h08, 6'h0A: begin
                c = '0; c.alu_src_a = 1;
                c.alu_src_b = (op == 6'h00) ? 2'b00 : 2'b10;
                c.alu_op    = (op == 6'h00) ? 2'b10 : 2'b11;
                push((op == 6'h00) ? 4'd7 : 4'd8, op, rnd(), 0, c);
                c = '0; c.reg_write = 1; c.reg_dst = (op == 6'h00);
                push(4'd9, op, rnd(), 1, c);
                n += 2;
            end
            6'h23, 6'h2B: begin
                c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
                push(4'd3, op, rnd(), 0, c); n++;
                for (int i = 0; i <= ms; i++) begin
                    c = '0; c.iord = 1;
                    if (op == 6'h23) begin
                        c.mem_read = 1;
                        push(4'd4, op, i == ms, 0, c);
                    end else begin
                        c.mem_write = 1;
                        push(4'd6, op, i == ms, i == ms, c);
                    end
                    n++;
                end
                if (op == 6'h23) begin
                    c = '0; c.reg_write = 1; c.mem_to_reg = 1;
                    push(4'd5, op, rnd(), 1, c); n++;
                end
            end
            6'h04, 6'h05: begin
                c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_write_cond = 1;
                c.pc_source = 2'b01; c.branch_eq = (op == 6'h04);
                push(4'd10, op, rnd(), 1, c); n++;
            end
            6'h02: begin
                c = '0; c.pc_write = 1; c.pc_source = 2'b10;
                push(4'd11, op, rnd(), 1, c); n++;
            end
            default: begin
                if (TRAP) begin
                    for (int i = 0; i < 20; i++) begin
                        c = '0; c.halt = 1;
                        push(4'd12, op, rnd(), 0, c); n++;
                    end
                end
            end
        endcase
        return n;
    endfunction

    // Entered and left aligned to a falling edge.
    task automatic run_q(input bit abort_memwr);
        ent_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            mem_ready_i = e.rdy;
            opcode_i    = (e.st == 4'd2) ? e.op : 6'($urandom);
            #1;
            chk("state", 32'(state_o), 32'(e.st));
            chk("ctl", 32'(dut_ctl), 32'(e.ctl));
            chk("count", 32'(instr_count_o), 32'(mcount));
            if (e.retire) mcount = mcount + CW'(1);
            if (abort_memwr && e.st == 4'd6 && !e.rdy) begin
                #1 rst_i = 1'b1;
                #1;
                chk("abort_mem_write", 32'(mem_write_o), 32'd0);
                chk("abort_ctl", 32'(dut_ctl), 32'd0);
                chk("abort_state", 32'(state_o), 32'd0);
                chk("abort_count", 32'(instr_count_o), 32'd0);
                q.delete();
                return;
            end
            @(negedge clk_i);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ctl", 32'(dut_ctl), 32'd0);
        chk("rst_count", 32'(instr_count_o), 32'd0);
        rst_i  = 1'b0;
        mcount = '0;
        q.delete();
        push(4'd0, 6'd0, rnd(), 0, '0);
        @(negedge clk_i);
    endtask

    logic [5:0] bulk_op [14] = '{6'h08, 6'h0A, 6'h2B, 6'h00, 6'h23, 6'h04, 6'h05,
                                 6'h02, 6'h00, 6'h08, 6'h2B, 6'h23, 6'h0A, 6'h04};
    int         bulk_fs [14] = '{0, 1, 0, 2, 1, 0, 3, 0, 0, 1, 0, 0, 2, 0};
    int         bulk_ms [14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 3, 0, 0};

    initial begin
        int n;
        do_reset();

        n = add_instr(6'h00, 0, 0);
        chk("len_rtype", 32'(n), 32'd4);
        run_q(0);
        #1 chk("cnt_after_rtype", 32'(instr_count_o), 32'd1);

        n = add_instr(6'h23, 0, 3);
        chk("len_lw_stall3", 32'(n), 32'd8);
        run_q(0);
        #1 chk("cnt_after_lw", 32'(instr_count_o), 32'd2);

        n = add_instr(6'h04, 0, 0);
        n = add_instr(6'h05, 0, 0);
        chk("len_bne", 32'(n), 32'd3);
        run_q(0);
        #1 chk("cnt_after_branches", 32'(instr_count_o), 32'd4);

        n = add_instr(6'h02, 0, 0);
        chk("len_jump", 32'(n), 32'd3);
        run_q(0);
        #1 chk("cnt_after_jump", 32'(instr_count_o), 32'd5);

        for (int i = 0; i < 14; i++) n = add_instr(bulk_op[i], bulk_fs[i], bulk_ms[i]);
        run_q(0);
        #1 chk("cnt_wrapped", 32'(instr_count_o), 32'd3);

        n = add_instr(6'h3F, 0, 0);
        run_q(0);
        #1 chk("cnt_after_illegal", 32'(instr_count_o), TRAP ? 32'd3 : 32'd4);
        chk("halt_after_illegal", 32'(halt_o), TRAP ? 32'd1 : 32'd0);

        do_reset();
        n = add_instr(6'h2B, 0, 5);
        run_q(1);

        do_reset();
        n = add_instr(6'h00, 1, 0);
        run_q(0);
        #1 chk("cnt_after_recovery", 32'(instr_count_o), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle version of the MIPS-subset CPU, where one ALU and one unified memory are reused across cycles. It sequences fetch, decode, execute, memory and writeback, and drives every mux select and write enable in the datapath. It also handshakes with a memory that may stall, and counts retired instructions.

Parameters:
COUNT_W, 32, width of the retired-instruction counter (wraps modulo 2^COUNT_W)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous reset, active-high
opcode_i  input  6  instruction[31:26] from the instruction register
mem_ready_i  input  1  memory completes the current access this cycle
pc_write_o  output  1  unconditional PC write
pc_write_cond_o  output  1  PC write qualified by branch compare
branch_eq_o  output  1  1=beq (take on zero), 0=bne (take on ~zero)
ir_write_o  output  1  instruction register load
iord_o  output  1  memory address select: 0=PC, 1=ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
mem_to_reg_o  output  1  writeback data select: 0=ALUOut, 1=MDR
reg_dst_o  output  1  destination select: 0=rt, 1=rd
reg_write_o  output  1  register file write enable
alu_src_a_o  output  1  ALU A select: 0=PC, 1=rs
alu_src_b_o  output  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
alu_op_o  output  2  00=add, 01=sub (compare), 10=R-type funct, 11=immediate op
pc_source_o  output  2  00=ALU result, 01=ALUOut (branch target), 10=jump address
halt_o  output  1  core halted on illegal opcode (feature only)
state_o  output  4  current state encoding, for debug
instr_count_o  output  COUNT_W  retired instruction count

Behaviour:
- Moore FSM with a registered state. Outputs decode from the state and from the latched opcode class; the only exception is the mem_ready_i gating described below.
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_RD=4, MEM_WB=5, MEM_WR=6, EXEC_R=7, EXEC_I=8, ALU_WB=9, BRANCH=10, JUMP=11, HALT=12.
- Reset (async, any state): state=IDLE, latched class cleared, instr_count_o=0. All outputs are 0 immediately, and any in-flight memory request is dropped.
- IDLE: all outputs 0; always moves to FETCH.
- FETCH: mem_read=1, iord=0, src_a=0, src_b=01, alu_op=00, pc_source=00.
  - If mem_ready_i=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - Otherwise stay in FETCH with ir_write=0 and pc_write=0.
- DECODE: src_a=0, src_b=11, alu_op=00 (precomputes the branch target). Latches opcode_i into a class register. Next state by opcode:
  - 0x00 -> EXEC_R
  - 0x23 (lw), 0x2B (sw) -> MEM_ADDR
  - 0x04 (beq), 0x05 (bne) -> BRANCH
  - 0x08 (addi), 0x0A (slti) -> EXEC_I
  - 0x02 (j) -> JUMP
  - anything else -> illegal-opcode handling (see Optional Feature)
- MEM_ADDR: src_a=1, src_b=10, alu_op=00. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Held until mem_ready_i=1, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH (retire).
- MEM_WR: iord=1, mem_write=1. Held until mem_ready_i=1, then FETCH (retire on the ready cycle).
- EXEC_R: src_a=1, src_b=00, alu_op=10, then ALU_WB.
- EXEC_I: src_a=1, src_b=10, alu_op=11, then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0, reg_dst=1 for R-type and 0 for immediate, then FETCH (retire).
- BRANCH: src_a=1, src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_eq=1 for beq and 0 for bne, then FETCH (retire).
- JUMP: pc_write=1, pc_source=10, then FETCH (retire).
- Outputs not listed for a state are 0.
- instr_count_o increments by 1 on each retiring transition and wraps to 0 after all-ones. It never increments in IDLE or HALT.
- mem_ready_i is ignored outside FETCH, MEM_RD and MEM_WR.
- Instruction latencies with mem_ready_i tied high (cycles):
  - R-type, immediate, sw: 4
  - lw: 5
  - branch, jump: 3
  - Each stalled cycle adds 1.

Optional Feature:
ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DECODE goes to HALT. HALT holds halt_o=1 and all other outputs 0 until reset; the illegal instruction is not counted.
- Undefined: an illegal opcode goes DECODE -> FETCH as a NOP and is counted as retired. HALT is unreachable and halt_o is tied 0.

Test Plan:
- Reset, then opcode 0x00 with ready=1 -> state_o 0,1,2,7,9,1; in state 9 reg_write=1 and reg_dst=1; instr_count_o=1.
- lw (0x23) with ready=0 for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_read=1 and iord=1 steady; then MEM_WB with reg_write=1, mem_to_reg=1; 8 cycles FETCH-to-FETCH.
- beq (0x04) then bne (0x05) -> BRANCH lasts one cycle with pc_write_cond=1 and pc_source=01; branch_eq=1 then 0; count +2.
- j (0x02) -> JUMP with pc_write=1 and pc_source=10; 3 cycles FETCH-to-FETCH.
- Opcode 0x3F -> with ILLEGAL_TRAP_EN, halt_o=1 persists for 20 cycles and count is unchanged; without it, FETCH follows DECODE and count +1.
- rst_i asserted mid-cycle during a MEM_WR stall -> mem_write_o and all outputs drop to 0 before the next edge; state_o=0, instr_count_o=0.
